// File: rtl/sar_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sar_pkg
//  Description : Shared types and constants for the successive-approximation
//                search engine (state encoding, default width, trial helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package sar_pkg;

    // Default trial/result width matches the existing 2-bit comparator.
    localparam int SAR_DEFAULT_WIDTH = 2;

    // Search controller states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        TEST = 2'b01,
        DONE = 2'b10
    } state_t;

    // Width of the bit-index register; at least one bit even for WIDTH=1.
    function automatic int sar_idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage : sar_pkg
`default_nettype wire

// File: rtl/sar_search.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search
//  Description : Successive-approximation search engine. Drives the trial
//                operand of an external greater-or-equal comparator and
//                recovers the unknown value one bit per cycle, MSB first.
//  Revision    : 1.0 - initial release
//
//  Parameters
//    WIDTH   : bit width of trial and result (>= 1)
//
//  Ports
//    clk     : rising-edge clock
//    rst_n   : asynchronous active-low reset
//    start   : request a new search, sampled only in IDLE
//    abort   : (SAR_ABORT_EN only) cancel a search in progress
//    cmp_ge  : comparator response, 1 iff unknown >= trial (same cycle)
//    trial   : current trial value driven to the comparator
//    busy    : high while the search is in TEST
//    done    : one-cycle pulse when result is updated
//    result  : last recovered value, held until the next completion
//
//  Configuration macro
//    SAR_ABORT_EN : adds the abort input; undefined means searches always
//                   run to completion.
// ============================================================================
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SAR_ABORT_EN
    input  logic             abort,
`endif
    input  logic             cmp_ge,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int               IDX_W     = sar_idx_width(WIDTH);
    localparam logic [WIDTH-1:0] TRIAL_MSB = WIDTH'(1) << (WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(WIDTH - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;

    logic [WIDTH-1:0] w_bit_mask;
    logic [WIDTH-1:0] w_resolved;
    logic [WIDTH-1:0] w_next_trial;
    logic             w_abort;

`ifdef SAR_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Only the bit under test may change: it is kept when the unknown is at
    // least the trial, cleared otherwise. Bits above it are already final.
    assign w_bit_mask   = WIDTH'(1) << r_idx;
    assign w_resolved   = cmp_ge ? trial : (trial & ~w_bit_mask);
    // Tentatively set the next lower bit; shifts out to zero at bit 0.
    assign w_next_trial = w_resolved | (w_bit_mask >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= IDX_TOP;
            trial   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    trial <= '0;
                    if (start) begin
                        trial   <= TRIAL_MSB;
                        r_idx   <= IDX_TOP;
                        busy    <= 1'b1;
                        r_state <= TEST;
                    end
                end

                TEST: begin
                    if (w_abort) begin
                        // Cancel: result keeps its previous value, no pulse.
                        trial   <= '0;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_idx != '0) begin
                        trial <= w_next_trial;
                        r_idx <= r_idx - IDX_W'(1);
                    end else begin
                        result  <= w_resolved;
                        trial   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    // start is ignored here; a new search is taken from IDLE.
                    done    <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    trial   <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : sar_search
`default_nettype wire

// File: tb/tb_sar_search.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sar_search
//  Description : Directed self-checking bench for sar_search. Three engines
//                (WIDTH = 2, 4, 1) each search a hidden value through a
//                behavioural greater-or-equal comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_search;

    logic       clk;
    logic       rst_n;

    logic       start2, start4, start1;
    logic [1:0] u2;
    logic [3:0] u4;
    logic       u1;

    logic [1:0] trial2, result2;
    logic [3:0] trial4, result4;
    logic       trial1, result1;
    logic       busy2, done2, busy4, done4, busy1, done1;
    logic       cmp2, cmp4, cmp1;

`ifdef SAR_ABORT_EN
    logic       abort4;
`endif

    int checks = 0;
    int errors = 0;

    // Comparators: y = (unknown >= trial)
    assign cmp2 = (u2 >= trial2);
    assign cmp4 = (u4 >= trial4);
    assign cmp1 = (u1 >= trial1);

    sar_search #(.WIDTH(2)) u_dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start2),
`ifdef SAR_ABORT_EN
        .abort  (1'b0),
`endif
        .cmp_ge (cmp2),
        .trial  (trial2),
        .busy   (busy2),
        .done   (done2),
        .result (result2)
    );

    sar_search #(.WIDTH(4)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start4),
`ifdef SAR_ABORT_EN
        .abort  (abort4),
`endif
        .cmp_ge (cmp4),
        .trial  (trial4),
        .busy   (busy4),
        .done   (done4),
        .result (result4)
    );

    sar_search #(.WIDTH(1)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start1),
`ifdef SAR_ABORT_EN
        .abort  (1'b0),
`endif
        .cmp_ge (cmp1),
        .trial  (trial1),
        .busy   (busy1),
        .done   (done1),
        .result (result1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=2 search from IDLE with hand-computed trial sequence.
    task automatic search2(input logic [1:0] u, input logic [1:0] t0,
                           input logic [1:0] t1, input logic [1:0] res,
                           input string tag);
        u2     = u;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check({tag, " trial0"}, 32'(trial2), 32'(t0));
        check({tag, " busy0"},  32'(busy2),  1);
        check({tag, " done0"},  32'(done2),  0);
        tick();
        check({tag, " trial1"}, 32'(trial2), 32'(t1));
        check({tag, " busy1"},  32'(busy2),  1);
        tick();
        check({tag, " done"},   32'(done2),  1);
        check({tag, " busyd"},  32'(busy2),  0);
        check({tag, " result"}, 32'(result2), 32'(res));
        check({tag, " trialz"}, 32'(trial2), 0);
        tick();
        check({tag, " donex"},  32'(done2),  0);
        check({tag, " hold"},   32'(result2), 32'(res));
    endtask

    initial begin
        logic [3:0] exp4 [4];
        logic [3:0] exp5 [4];
        int         busy_cnt;

        rst_n  = 1'b0;
        start2 = 1'b0;
        start4 = 1'b0;
        start1 = 1'b0;
        u2     = 2'b00;
        u4     = 4'd0;
        u1     = 1'b0;
`ifdef SAR_ABORT_EN
        abort4 = 1'b0;
`endif
        tick();
        tick();
        check("rst trial",  32'(trial2),  0);
        check("rst busy",   32'(busy2),   0);
        check("rst done",   32'(done2),   0);
        check("rst result", 32'(result2), 0);
        check("rst trial4", 32'(trial4),  0);
        rst_n = 1'b1;
        tick();

        // All four WIDTH=2 unknowns recover exactly.
        search2(2'b10, 2'b10, 2'b11, 2'b10, "w2 u10");
        search2(2'b00, 2'b10, 2'b01, 2'b00, "w2 u00");
        search2(2'b11, 2'b10, 2'b11, 2'b11, "w2 u11");
        search2(2'b01, 2'b10, 2'b01, 2'b01, "w2 u01");

        // WIDTH=4, unknown 9: trials 8,12,10,9; busy exactly 4 cycles.
        exp4 = '{4'd8, 4'd12, 4'd10, 4'd9};
        u4       = 4'd9;
        busy_cnt = 0;
        start4   = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("w4 trial", 32'(trial4), 32'(exp4[i]));
            if (busy4) busy_cnt++;
            tick();
        end
        check("w4 busycnt", 32'(busy_cnt), 4);
        check("w4 busyend", 32'(busy4),    0);
        check("w4 done",    32'(done4),    1);
        check("w4 result",  32'(result4),  9);
        tick();
        check("w4 donex",   32'(done4),    0);

        // start held high: back-to-back searches every 4 cycles, starts in
        // TEST/DONE ignored.
        u2     = 2'b01;
        start2 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("b2b t0",    32'(trial2), 2);
            check("b2b busy",  32'(busy2),  1);
            tick();
            check("b2b t1",    32'(trial2), 1);
            tick();
            check("b2b done",  32'(done2),  1);
            check("b2b res",   32'(result2), 1);
            tick();
            check("b2b idle",  32'(busy2),  0);
            check("b2b idled", 32'(done2),  0);
            check("b2b idlet", 32'(trial2), 0);
        end
        start2 = 1'b0;
        tick();
        check("b2b stop", 32'(busy2), 0);

        // Asynchronous reset during the second TEST cycle.
        u2     = 2'b10;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        check("mid busy pre", 32'(busy2), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst trial",  32'(trial2),  0);
        check("arst busy",   32'(busy2),   0);
        check("arst done",   32'(done2),   0);
        check("arst result", 32'(result2), 0);
        tick();
        check("arst nodone", 32'(done2),   0);
        #2;
        rst_n = 1'b1;
        tick();
        check("arst stay",   32'(done2),   0);
        search2(2'b11, 2'b10, 2'b11, 2'b11, "post rst");

        // WIDTH=1: single TEST cycle, trial=1, result=cmp_ge.
        u1     = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("w1 trial", 32'(trial1), 1);
        check("w1 busy",  32'(busy1),  1);
        tick();
        check("w1 done",  32'(done1),  1);
        check("w1 res1",  32'(result1), 1);
        tick();
        u1     = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        check("w1 done0", 32'(done1),  1);
        check("w1 res0",  32'(result1), 0);
        tick();

`ifdef SAR_ABORT_EN
        // Search for 9 first so the abort has a previous result to keep.
        u4     = 4'd9;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("ab prev", 32'(result4), 9);
        // unknown 5, abort at the second TEST edge.
        u4     = 4'd5;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("ab t0", 32'(trial4), 8);
        tick();
        check("ab t1", 32'(trial4), 4);
        abort4 = 1'b1;
        tick();
        abort4 = 1'b0;
        check("ab trial",  32'(trial4),  0);
        check("ab busy",   32'(busy4),   0);
        check("ab done",   32'(done4),   0);
        check("ab result", 32'(result4), 9);
        tick();
        check("ab nodone", 32'(done4),   0);
        // abort together with start in IDLE: start still accepted.
        exp5 = '{4'd8, 4'd4, 4'd6, 4'd5};
        abort4 = 1'b1;
        start4 = 1'b1;
        tick();
        abort4 = 1'b0;
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ab2 trial", 32'(trial4), 32'(exp5[i]));
            tick();
        end
        check("ab2 done",   32'(done4),   1);
        check("ab2 result", 32'(result4), 5);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sar_search
`default_nettype wire
